// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the inst/data RAM port arbiter.
package mem_arb_pkg;
   localparam int DEF_ADDR_WIDTH = 15;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_INST} state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_DATA, GNT_INST} gnt_t;
endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data wins while the fetch side waits; o_sat forces the
// next contended cycle to the fetch side.
module arb_starve_counter #(
   parameter int STARVE_LIMIT = 4,
   localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_sat
);
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !o_sat) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_sat = (r_cnt == CW'(STARVE_LIMIT));
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between fetch and load/store; grant is combinational,
// read data returns registered one cycle after the ack.
module ram_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  inst_req,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic                  inst_ack,
   output logic                  inst_rvalid,
   output logic [DATA_WIDTH-1:0] inst_rdata,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic                  data_ack,
   output logic                  data_rvalid,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [DATA_WIDTH-1:0] ram_d,
   input  logic [DATA_WIDTH-1:0] ram_spo
);
   gnt_t                  w_gnt;
   logic                  w_sat;
   state_t                r_state;
   logic                  r_data_rd;
   logic [DATA_WIDTH-1:0] r_inst_rdata;
   logic [DATA_WIDTH-1:0] r_data_rdata;

   // Data normally wins contention; the fetch side wins once it has been starved long enough.
   always_comb begin
      w_gnt = GNT_NONE;
      if (!resetn) begin
         w_gnt = GNT_NONE;
      end else if (data_req && inst_req) begin
         w_gnt = w_sat ? GNT_INST : GNT_DATA;
      end else if (data_req) begin
         w_gnt = GNT_DATA;
      end else if (inst_req) begin
         w_gnt = GNT_INST;
      end
   end

   assign inst_ack = (w_gnt == GNT_INST);
   assign data_ack = (w_gnt == GNT_DATA);
   assign ram_we   = data_ack && data_we;
   assign ram_a    = data_ack ? data_addr : (inst_ack ? inst_addr : '0);
   assign ram_d    = (w_gnt != GNT_NONE) ? data_wdata : '0;

   arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk    (clk),
      .resetn (resetn),
      .i_clr  (inst_ack),
      .i_inc  (data_ack && inst_req),
      .o_sat  (w_sat)
   );

   // ram_spo is only captured on read grants; it is not valid during a write.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_data_rd    <= 1'b0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
      end else begin
         case (w_gnt)
            GNT_DATA: begin
               r_state   <= S_DATA;
               r_data_rd <= !data_we;
               if (!data_we) r_data_rdata <= ram_spo;
            end
            GNT_INST: begin
               r_state      <= S_INST;
               r_data_rd    <= 1'b0;
               r_inst_rdata <= ram_spo;
            end
            default: begin
               r_state   <= S_IDLE;
               r_data_rd <= 1'b0;
            end
         endcase
      end
   end

   assign inst_rvalid = (r_state == S_INST);
   assign data_rvalid = (r_state == S_DATA) && r_data_rd;
   assign inst_rdata  = r_inst_rdata;
   assign data_rdata  = r_data_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table, corner-case sequences and a randomized
// run against a behavioural RAM plus reference model.
module tb_ram_port_arbiter;
   localparam int AW = 15;
   localparam int DW = 32;
   localparam int LIM = 4;

   logic          clk;
   logic          resetn;
   logic          inst_req, data_req, data_we;
   logic [AW-1:0] inst_addr, data_addr;
   logic [DW-1:0] data_wdata;
   logic          inst_ack, data_ack, inst_rvalid, data_rvalid;
   logic [DW-1:0] inst_rdata, data_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_a;
   logic [DW-1:0] ram_d, ram_spo;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:15];

   int total = 0;
   int bad = 0;

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
      .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_ack(data_ack),
      .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_spo(ram_spo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM; read data is poisoned while writing.
   assign ram_spo = ram_we ? 32'hBAD0_BAD0 : mem[ram_a];
   always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;

   typedef struct {
      logic          ireq, dreq, dwe;
      logic [AW-1:0] ia, da;
      logic [DW-1:0] wd;
      logic          e_iack, e_dack, e_we;
      logic [AW-1:0] e_a;
      logic          e_irv, e_drv;
      logic [DW-1:0] e_ird, e_drd;
   } vec_t;

   vec_t tbl [9];

   function automatic vec_t mkv(logic ireq, logic dreq, logic dwe, logic [AW-1:0] ia,
                                logic [AW-1:0] da, logic [DW-1:0] wd, logic e_iack,
                                logic e_dack, logic e_we, logic [AW-1:0] e_a, logic e_irv,
                                logic e_drv, logic [DW-1:0] e_ird, logic [DW-1:0] e_drd);
      vec_t v;
      v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.ia = ia; v.da = da; v.wd = wd;
      v.e_iack = e_iack; v.e_dack = e_dack; v.e_we = e_we; v.e_a = e_a;
      v.e_irv = e_irv; v.e_drv = e_drv; v.e_ird = e_ird; v.e_drd = e_drd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
      inst_addr = '0; data_addr = '0; data_wdata = '0;
   endtask

   task automatic do_reset();
      idle();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
   endtask

   initial begin
      logic          g_d, g_i, pend_irv, pend_drv;
      logic [DW-1:0] exp_ird, exp_drd;
      int            wait_cnt;

      resetn = 1'b1;
      idle();
      #1;
      // Reset: requests present but everything held quiet.
      resetn = 1'b0;
      inst_req = 1'b1; data_req = 1'b1; data_we = 1'b1;
      data_addr = 15'h0005; data_wdata = 32'h1111_2222;
      #2;
      chk("rst_iack", inst_ack, 0);
      chk("rst_dack", data_ack, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_irv", inst_rvalid, 0);
      chk("rst_drv", data_rvalid, 0);
      chk("rst_ird", inst_rdata, 0);
      chk("rst_drd", data_rdata, 0);
      step();
      step();
      idle();
      resetn = 1'b1;

      // Table: single inst read, write-then-read, idle hold, write then inst read-after-write.
      mem[15'h0010] = 32'hDEAD_BEEF;
      mem[15'h0020] = 32'h0;
      mem[15'h0030] = 32'h0;
      tbl[0] = mkv(1,0,0, 15'h10, 15'h0,  32'h0,         1,0,0, 15'h10, 0,0, 32'h0,         32'h0);
      tbl[1] = mkv(0,1,1, 15'h0,  15'h20, 32'h1234_5678, 0,1,1, 15'h20, 1,0, 32'hDEAD_BEEF, 32'h0);
      tbl[2] = mkv(0,1,0, 15'h0,  15'h20, 32'h0,         0,1,0, 15'h20, 0,0, 32'hDEAD_BEEF, 32'h0);
      tbl[3] = mkv(0,0,0, 15'h0,  15'h0,  32'h0,         0,0,0, 15'h0,  0,1, 32'hDEAD_BEEF, 32'h1234_5678);
      tbl[4] = mkv(0,0,0, 15'h0,  15'h0,  32'h0,         0,0,0, 15'h0,  0,0, 32'hDEAD_BEEF, 32'h1234_5678);
      tbl[5] = mkv(0,0,0, 15'h0,  15'h0,  32'h0,         0,0,0, 15'h0,  0,0, 32'hDEAD_BEEF, 32'h1234_5678);
      tbl[6] = mkv(1,1,1, 15'h30, 15'h30, 32'hCAFE_F00D, 0,1,1, 15'h30, 0,0, 32'hDEAD_BEEF, 32'h1234_5678);
      tbl[7] = mkv(1,0,0, 15'h30, 15'h0,  32'h0,         1,0,0, 15'h30, 0,0, 32'hDEAD_BEEF, 32'h1234_5678);
      tbl[8] = mkv(0,0,0, 15'h0,  15'h0,  32'h0,         0,0,0, 15'h0,  1,0, 32'hCAFE_F00D, 32'h1234_5678);
      for (int i = 0; i < 9; i++) begin
         inst_req = tbl[i].ireq; data_req = tbl[i].dreq; data_we = tbl[i].dwe;
         inst_addr = tbl[i].ia; data_addr = tbl[i].da; data_wdata = tbl[i].wd;
         #1;
         chk($sformatf("v%0d_iack", i), inst_ack, tbl[i].e_iack);
         chk($sformatf("v%0d_dack", i), data_ack, tbl[i].e_dack);
         chk($sformatf("v%0d_ram_we", i), ram_we, tbl[i].e_we);
         chk($sformatf("v%0d_ram_a", i), ram_a, tbl[i].e_a);
         if (tbl[i].e_dack) chk($sformatf("v%0d_ram_d", i), ram_d, tbl[i].wd);
         else if (!tbl[i].e_iack) chk($sformatf("v%0d_ram_d", i), ram_d, 0);
         chk($sformatf("v%0d_irv", i), inst_rvalid, tbl[i].e_irv);
         chk($sformatf("v%0d_drv", i), data_rvalid, tbl[i].e_drv);
         chk($sformatf("v%0d_ird", i), inst_rdata, tbl[i].e_ird);
         chk($sformatf("v%0d_drd", i), data_rdata, tbl[i].e_drd);
         step();
      end

      // Reset in the middle of a granted data read.
      do_reset();
      mem[15'h0040] = 32'h55AA_55AA;
      data_req = 1'b1; data_we = 1'b0; data_addr = 15'h0040;
      #1;
      chk("mid_dack", data_ack, 1);
      #2;
      resetn = 1'b0;
      data_we = 1'b1;
      #1;
      chk("mid_ram_we", ram_we, 0);
      chk("mid_dack_rst", data_ack, 0);
      step();
      chk("mid_drv_rst", data_rvalid, 0);
      idle();
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("mid_drv_%0d", i), data_rvalid, 0);
         chk($sformatf("mid_drd_%0d", i), data_rdata, 0);
         step();
      end

      // Contention straight after reset: every fifth grant goes to inst.
      for (int i = 0; i < 20; i++) begin
         inst_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
         inst_addr = AW'(i); data_addr = AW'(100 + i);
         #1;
         chk($sformatf("cont_iack_%0d", i), inst_ack, (i % 5) == 4);
         chk($sformatf("cont_dack_%0d", i), data_ack, (i % 5) != 4);
         step();
      end

      // Alternating load: data every other cycle with inst always pending.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         inst_req = 1'b1; data_req = (i % 2) == 0; data_we = 1'b0;
         #1;
         chk($sformatf("alt_dack_%0d", i), data_ack, (i % 2) == 0);
         chk($sformatf("alt_iack_%0d", i), inst_ack, (i % 2) == 1);
         chk($sformatf("alt_irv_%0d", i), inst_rvalid, (i > 0) && ((i % 2) == 0));
         step();
      end

      // Randomized traffic against the reference model.
      do_reset();
      for (int a = 0; a < 16; a++) begin
         mem[a] = $urandom;
         ref_mem[a] = mem[a];
      end
      wait_cnt = 0; pend_irv = 1'b0; pend_drv = 1'b0;
      exp_ird = '0; exp_drd = '0;
      for (int i = 0; i < 400; i++) begin
         inst_req = ($urandom % 4) != 0;
         data_req = ($urandom % 4) != 0;
         data_we = $urandom_range(0, 1);
         inst_addr = AW'($urandom % 16);
         data_addr = AW'($urandom % 16);
         data_wdata = $urandom;
         #1;
         g_d = data_req && !(inst_req && wait_cnt == LIM);
         g_i = inst_req && !g_d;
         chk("rnd_iack", inst_ack, g_i);
         chk("rnd_dack", data_ack, g_d);
         chk("rnd_ram_we", ram_we, g_d && data_we);
         chk("rnd_ram_a", ram_a, g_d ? data_addr : (g_i ? inst_addr : '0));
         if (g_d) chk("rnd_ram_d", ram_d, data_wdata);
         chk("rnd_irv", inst_rvalid, pend_irv);
         chk("rnd_drv", data_rvalid, pend_drv);
         chk("rnd_ird", inst_rdata, exp_ird);
         chk("rnd_drd", data_rdata, exp_drd);
         pend_irv = g_i;
         pend_drv = g_d && !data_we;
         if (g_d) begin
            if (data_we) ref_mem[data_addr[3:0]] = data_wdata;
            else exp_drd = ref_mem[data_addr[3:0]];
            if (inst_req && wait_cnt < LIM) wait_cnt++;
         end
         if (g_i) begin
            exp_ird = ref_mem[inst_addr[3:0]];
            wait_cnt = 0;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
